// File: rtl/full_adder_checker.sv
// Checks a full adder's sum/carry against a reference, counting passes and
// fails and tracking which input combinations have been exercised in a run.
module full_adder_checker #(
  parameter int CNT_W      = 8,
  parameter int MAX_CHECKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             all_covered,
  output logic [7:0]       coverage,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic [4:0]       first_fail
);

  localparam int               TOT_W   = $clog2(MAX_CHECKS + 1);
  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_CHECKS);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] total_nxt;
  logic [7:0]       cov_nxt;
  logic [2:0]       idx;
  logic             exp_sum;
  logic             exp_carry;
  logic             match;

  assign exp_sum     = a ^ b ^ c;
  assign exp_carry   = (a & b) | (a & c) | (b & c);
  assign match       = (sum == exp_sum) && (carry == exp_carry);
  assign idx         = {a, b, c};
  assign cov_nxt     = coverage | (8'b1 << idx);
  assign total_nxt   = total + TOT_W'(1);
  assign all_covered = (coverage == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      coverage   <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      total      <= '0;
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else begin
      mismatch <= 1'b0;
      // start wins in every state, and discards any sample presented with it
      if (start) begin
        state      <= RUN;
        busy       <= 1'b1;
        done       <= 1'b0;
        coverage   <= '0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        total      <= '0;
        first_fail <= '0;
      end else begin
        case (state)
          RUN: begin
            if (in_valid) begin
              total    <= total_nxt;
              coverage <= cov_nxt;
              if (match) begin
                if (pass_cnt != CNT_SAT) pass_cnt <= pass_cnt + CNT_W'(1);
              end else begin
                if (fail_cnt != CNT_SAT) fail_cnt <= fail_cnt + CNT_W'(1);
                mismatch <= 1'b1;
                if (fail_cnt == '0) first_fail <= {a, b, c, sum, carry};
              end
              if (cov_nxt == 8'hFF || total_nxt == TOT_MAX) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          IDLE, DONE: ;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_full_adder_checker.sv
// Scoreboard bench for full_adder_checker: three instances cover the default,
// short-timeout and narrow-counter configurations from one shared stimulus.
module tb_full_adder_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, sum = 1'b0, carry = 1'b0;

  logic       busy0, done0, allc0, mism0;
  logic [7:0] cov0, pass0, fail0;
  logic [4:0] ff0;
  logic       busy1, done1, allc1, mism1;
  logic [7:0] cov1, pass1, fail1;
  logic [4:0] ff1;
  logic       busy2, done2, allc2, mism2;
  logic [7:0] cov2;
  logic [1:0] pass2, fail2;
  logic [4:0] ff2;

  full_adder_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(busy0), .done(done0), .all_covered(allc0), .coverage(cov0),
    .pass_cnt(pass0), .fail_cnt(fail0), .mismatch(mism0), .first_fail(ff0));

  full_adder_checker #(.MAX_CHECKS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(busy1), .done(done1), .all_covered(allc1), .coverage(cov1),
    .pass_cnt(pass1), .fail_cnt(fail1), .mismatch(mism1), .first_fail(ff1));

  full_adder_checker #(.CNT_W(2), .MAX_CHECKS(64)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(busy2), .done(done2), .all_covered(allc2), .coverage(cov2),
    .pass_cnt(pass2), .fail_cnt(fail2), .mismatch(mism2), .first_fail(ff2));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          dut;
    logic [32:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {pass, fail, coverage, mismatch, busy, done, all_covered, first_fail}
  function automatic logic [32:0] snap(int d);
    case (d)
      0:       return {pass0, fail0, cov0, mism0, busy0, done0, allc0, ff0};
      1:       return {pass1, fail1, cov1, mism1, busy1, done1, allc1, ff1};
      default: return {6'b0, pass2, 6'b0, fail2, cov2, mism2, busy2, done2, allc2, ff2};
    endcase
  endfunction

  function automatic string fmt(logic [32:0] v);
    return $sformatf("pass=%0d fail=%0d cov=%h mism=%b busy=%b done=%b allc=%b ff=%b",
                     v[32:25], v[24:17], v[16:9], v[8], v[7], v[6], v[5], v[4:0]);
  endfunction

  task automatic check(string name, logic [32:0] got, logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
    end
  endtask

  function automatic logic [32:0] mk(int p, int f, logic [7:0] cov, logic m,
                                     logic bs, logic dn, logic [4:0] ff);
    return {8'(p), 8'(f), cov, m, bs, dn, (cov == 8'hFF), ff};
  endfunction

  task automatic expect_s(int d, string nm, int p, int f, logic [7:0] cov,
                          logic m, logic bs, logic dn, logic [4:0] ff);
    exp_t e;
    e.cyc  = cyc + 1;
    e.dut  = d;
    e.exp  = mk(p, f, cov, m, bs, dn, ff);
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic drive(logic st, logic v, logic [2:0] abc, logic s, logic co);
    @(posedge clk);
    #1;
    start = st; in_valid = v; {a, b, c} = abc; sum = s; carry = co;
  endtask

  task automatic drive_good(logic [2:0] abc);
    drive(1'b0, 1'b1, abc, ^abc, (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]));
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else begin
        check(e.name, snap(e.dut), e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, required < 100000", $time);
    $fatal(1);
  end

  initial begin
    // reset state, then samples in IDLE must be ignored
    repeat (2) @(posedge clk);
    #1;
    expect_s(0, "reset_u0", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    expect_s(1, "reset_u1", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    expect_s(2, "reset_u2", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(0, 1, 3'b011, 0, 1);
    expect_s(0, "idle_ignore_u0", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    drive(0, 1, 3'b000, 1, 0);
    expect_s(2, "idle_ignore_u2", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    expect_s(0, "idle_ignore_u0b", 0, 0, 8'h00, 0, 0, 0, 5'b0);

    // clean sweep
    drive(1, 0, 3'b000, 0, 0);
    expect_s(0, "sweep_start", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    for (int i = 0; i < 8; i++) begin
      drive_good(3'(i));
      expect_s(0, $sformatf("sweep_%0d", i), i + 1, 0, 8'((1 << (i + 1)) - 1),
               0, (i != 7), (i == 7), 5'b0);
    end
    drive(0, 1, 3'b110, 1, 1);
    expect_s(0, "done_ignores_valid", 8, 0, 8'hFF, 0, 0, 1, 5'b0);

    // fault injection
    drive(1, 0, 3'b000, 0, 0);
    expect_s(0, "fault_start", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    drive(0, 1, 3'b000, 0, 0);
    expect_s(0, "fault_s1", 1, 0, 8'h01, 0, 1, 0, 5'b0);
    drive(0, 1, 3'b001, 1, 0);
    expect_s(0, "fault_s2", 2, 0, 8'h03, 0, 1, 0, 5'b0);
    drive(0, 1, 3'b110, 1, 1);
    expect_s(0, "fault_s3", 2, 1, 8'h43, 1, 1, 0, 5'b11011);
    drive(0, 1, 3'b111, 1, 1);
    expect_s(0, "fault_s4", 3, 1, 8'hC3, 0, 1, 0, 5'b11011);
    drive(0, 1, 3'b010, 0, 1);
    expect_s(0, "fault_s5", 3, 2, 8'hC7, 1, 1, 0, 5'b11011);
    drive(0, 1, 3'b011, 1, 0);
    expect_s(0, "fault_s6_consec", 3, 3, 8'hCF, 1, 1, 0, 5'b11011);
    drive(0, 0, 3'b000, 0, 0);
    expect_s(0, "fault_hold", 3, 3, 8'hCF, 0, 1, 0, 5'b11011);

    // start with in_valid in RUN: sample dropped
    drive(1, 1, 3'b111, 1, 1);
    expect_s(0, "restart_clear", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    drive(0, 0, 3'b000, 0, 0);
    expect_s(0, "restart_not_counted", 0, 0, 8'h00, 0, 1, 0, 5'b0);

    // timeout on the MAX_CHECKS=4 instance, then restart from DONE
    drive(1, 0, 3'b000, 0, 0);
    expect_s(1, "tmo_start", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 3'b011, 0, 1);
      expect_s(1, $sformatf("tmo_%0d", k), k, 0, 8'h08, 0, (k != 4), (k == 4), 5'b0);
    end
    drive(1, 0, 3'b000, 0, 0);
    expect_s(1, "start_in_done", 0, 0, 8'h00, 0, 1, 0, 5'b0);

    // saturation on the CNT_W=2 instance
    for (int k = 1; k <= 6; k++) begin
      drive(0, 1, 3'b000, 1, 0);
      expect_s(2, $sformatf("sat_%0d", k), 0, (k < 3) ? k : 3, 8'h01, 1, 1, 0, 5'b00010);
    end

    // reset mid-run
    drive(1, 0, 3'b000, 0, 0);
    expect_s(0, "mid_start", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    for (int i = 0; i < 3; i++) begin
      drive_good(3'(i));
      expect_s(0, $sformatf("mid_%0d", i), i + 1, 0, 8'((1 << (i + 1)) - 1), 0, 1, 0, 5'b0);
    end
    drive(0, 0, 3'b000, 0, 0);
    expect_s(0, "mid_hold", 3, 0, 8'h07, 0, 1, 0, 5'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_u0", snap(0), mk(0, 0, 8'h00, 0, 0, 0, 5'b0));
    check("async_reset_u1", snap(1), mk(0, 0, 8'h00, 0, 0, 0, 5'b0));
    check("async_reset_u2", snap(2), mk(0, 0, 8'h00, 0, 0, 0, 5'b0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive_good(3'b100);
    expect_s(0, "post_reset_idle", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    drive_good(3'b110);
    expect_s(0, "post_reset_idle2", 0, 0, 8'h00, 0, 0, 0, 5'b0);
    drive(1, 0, 3'b000, 0, 0);
    expect_s(0, "post_reset_start", 0, 0, 8'h00, 0, 1, 0, 5'b0);
    drive_good(3'b101);
    expect_s(0, "post_reset_check", 1, 0, 8'h20, 0, 1, 0, 5'b0);
    drive(0, 0, 3'b000, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_checker.md
FULL_ADDER_CHECKER -- requirements
Module: full_adder_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the pass and fail counters.
REQ-002 SHALL have parameter MAX_CHECKS, default 64: the total number of checks after which a run ends even if coverage is incomplete.
REQ-003 Clocking and reset SHALL be as decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse that clears all results and begins a run.
REQ-007 in_valid  input  1  the a/b/c/sum/carry sample presented this cycle is valid.
REQ-008 a, b, c  input  1 each  adder operand bits and carry-in, as applied to the adder under test.
REQ-009 sum, carry  input  1 each  adder under test outputs for the same a/b/c.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.
REQ-012 all_covered  output  1  high when all 8 input combinations have been seen in the current run.
REQ-013 coverage  output  8  bit {a,b,c} is set once that combination has been checked.
REQ-014 pass_cnt, fail_cnt  output  CNT_W each  number of matching and mismatching checks.
REQ-015 mismatch  output  1  one-cycle pulse flagging a failed check.
REQ-016 first_fail  output  5  {a,b,c,sum,carry} captured from the first failing sample in the run.

Function
REQ-017 The block SHALL compute the expected values combinationally: exp_sum = a^b^c, exp_carry = (a&b)|(a&c)|(b&c).
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 IDLE: in_valid SHALL be ignored; start SHALL clear all results and enter RUN on the next edge.
REQ-020 RUN: a check is sampled on each edge where in_valid=1 and start=0.
REQ-021 A sample matches when sum==exp_sum and carry==exp_carry; a match SHALL increment pass_cnt.
REQ-022 A non-matching sample SHALL increment fail_cnt.
REQ-023 Counter, coverage, mismatch and first_fail updates SHALL be visible one cycle after the sampling edge (registered outputs, latency 1).
REQ-024 On a failing sample, mismatch SHALL pulse high for exactly one cycle; consecutive failures SHALL keep it high for the same number of cycles.
REQ-025 first_fail SHALL be loaded only when fail_cnt is 0 before the failing sample, and SHALL then hold until cleared.
REQ-026 Every check SHALL set coverage[{a,b,c}], whether it passes or fails.
REQ-027 pass_cnt and fail_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 An internal total counter SHALL count all checks in the run and SHALL be wide enough to represent MAX_CHECKS.
REQ-029 RUN SHALL go to DONE on the edge where the updated coverage becomes 8'hFF or the updated total equals MAX_CHECKS, whichever occurs first; that check SHALL be counted.
REQ-030 all_covered SHALL equal (coverage==8'hFF) and SHALL be valid in every state.
REQ-031 DONE: in_valid SHALL be ignored; all results SHALL hold; start SHALL clear and re-enter RUN.
REQ-032 start in RUN SHALL clear all results and remain in RUN; an in_valid in the same cycle SHALL be discarded (start has priority).
REQ-033 On the edge following a start, pass_cnt, fail_cnt, the total counter, coverage and first_fail SHALL be 0 and mismatch SHALL be 0.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE; busy=0; done=0; all_covered=0; coverage=0; pass_cnt=0; fail_cnt=0; total=0; mismatch=0; first_fail=0.
REQ-035 Reset assertion mid-run SHALL discard the run; after release, the block SHALL wait in IDLE for start.
REQ-036 Reset release SHALL be sampled synchronously to clk.

Verification
REQ-037 Clean sweep: start, then 8 valid samples with {a,b,c}=0..7 and correct sum/carry -> pass_cnt=8, fail_cnt=0, coverage=8'hFF, done=1 one cycle after the 8th sample, busy=0.
REQ-038 Fault injection: a,b,c=1,1,0 with sum=1, carry=1 as the 3rd sample -> mismatch pulses one cycle, fail_cnt=1, first_fail=5'b11011; a later failure leaves first_fail unchanged.
REQ-039 Timeout: with MAX_CHECKS=4, send {a,b,c}=3 four times -> done=1, all_covered=0, coverage=8'b0000_1000, pass_cnt=4.
REQ-040 Saturation: with CNT_W=2 and MAX_CHECKS=64, send 6 failing samples -> fail_cnt holds at 3; in_valid while IDLE leaves all counters 0.
REQ-041 Restart/priority: start and in_valid together in RUN -> counters 0 next cycle and the sample is not counted; start in DONE -> busy=1, done=0, coverage=0.
REQ-042 Reset mid-run: drop rst_n after 3 checks -> all outputs 0 asynchronously, state IDLE; samples after release are ignored until start.
